// File: rtl/sin_pwm_dac.sv
`timescale 1ns/1ps
// sin_pwm_dac
// Output stage of the sine generator. It owns the 9-bit phase address sent to
// the sine lookup block and captures the 8-bit sample that block returns. Each
// captured sample becomes the duty cycle of one 256-tick PWM period. The phase
// advances by 'step' once per period.
//
// Parameters:
//   PRESCALE      clk cycles per PWM tick (>=1)
//   ROM_LAT       clk cycles from a count change to valid val (>=1)
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   en            run enable; low freezes phase and PWM
//   step   [8:0]  phase increment applied at each period end
//   val    [7:0]  sample from the sine lookup block
//   count  [8:0]  phase address to the sine lookup block
//   pwm_out       PWM DAC output
//   period_start  one-cycle pulse on the first cycle of each PWM period
//   duty   [7:0]  duty value of the current period
module sin_pwm_dac #(
    parameter int PRESCALE = 1,
    parameter int ROM_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [8:0] step,
    input  logic [7:0] val,
    output logic [8:0] count,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty
);

    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]  r_presc;
    logic [7:0]     r_pwm_cnt;
    logic [7:0]     r_duty;
    logic [7:0]     r_duty_next;
    logic [8:0]     r_count;
    logic           r_pwm_out;
    logic           r_period_start;
    logic [ROM_LAT:0] r_cap;

    logic w_tick;
    logic w_period_end;

    assign w_tick       = en && (r_presc == PRESC_MAX);
    assign w_period_end = w_tick && (r_pwm_cnt == 8'hFF);

    // Prescaler and PWM tick counter; both hold while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else if (en) begin
            r_presc   <= r_presc + 1'b1;
        end
    end

    // Registered comparator: output lags pwm_cnt by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_out <= 1'b0;
        end else begin
            r_pwm_out <= en && (r_pwm_cnt < r_duty);
        end
    end

    // Period end: load the prefetched sample, advance the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty         <= '0;
            r_count        <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_period_end;
            if (w_period_end) begin
                r_duty  <= r_duty_next;
                r_count <= r_count + step;
            end
        end
    end

    // Capture pipeline: a pulse enters with every count update and samples val
    // when it falls out, ROM_LAT+1 edges later. Reset preloads one pulse so the
    // sample for count=0 is fetched right after reset. Runs regardless of en so
    // an in-flight fetch always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap       <= {{ROM_LAT{1'b0}}, 1'b1};
            r_duty_next <= '0;
        end else begin
            r_cap <= {r_cap[ROM_LAT-1:0], w_period_end};
            if (r_cap[ROM_LAT]) begin
                r_duty_next <= val;
            end
        end
    end

    assign count        = r_count;
    assign pwm_out      = r_pwm_out;
    assign period_start = r_period_start;
    assign duty         = r_duty;

endmodule

// File: tb/tb_sin_pwm_dac.sv
`timescale 1ns/1ps
// Bench for sin_pwm_dac. Two instances share clk/rst_n/en/step:
// index 0 runs PRESCALE=1/ROM_LAT=1, index 1 runs PRESCALE=4/ROM_LAT=2.
// Each has its own sine-ROM stub (table or constant) with ROM_LAT latency.
// A per-period reference model predicts count, duty, period length and the
// number of pwm_out high cycles in each period.
module tb_sin_pwm_dac;

    localparam int NI = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic [8:0] step  = '0;

    logic [7:0] val          [NI];
    logic [8:0] count        [NI];
    logic       pwm_out      [NI];
    logic       period_start [NI];
    logic [7:0] duty         [NI];

    int n_tests = 0;
    int n_fail  = 0;

    int   sine [512];
    logic mode_tab = 1'b0;
    int   cval     = 64;

    int pc      [NI];
    int m_count [NI];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int src(input int c);
        return mode_tab ? sine[c] : cval;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int P = (g == 0) ? 1 : 4;
        localparam int L = g + 1;

        logic [7:0] rq [L];
        int   hi, dis, m_duty, m_next;
        logic prev_en, prev_ps;
        logic [8:0] prev_step;

        sin_pwm_dac #(.PRESCALE(P), .ROM_LAT(L)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .step         (step),
            .val          (val[g]),
            .count        (count[g]),
            .pwm_out      (pwm_out[g]),
            .period_start (period_start[g]),
            .duty         (duty[g])
        );

        // ROM stub: val is valid L cycles after count changes.
        always @(posedge clk) begin
            rq[0] <= 8'(src(int'(count[g])));
            for (int i = 1; i < L; i++) rq[i] <= rq[i-1];
        end
        assign val[g] = rq[L-1];

        // Reference model, evaluated once per cycle away from the active edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                pc[g] = 0; hi = 0; dis = 0;
                m_count[g] = 0; m_duty = 0; m_next = 0;
                prev_en = 1'b0; prev_ps = 1'b0; prev_step = '0;
            end else begin
                if (period_start[g]) begin
                    chk($sformatf("len%0d", g), pc[g], 256 * P + dis);
                    chk($sformatf("hi%0d", g), hi, m_duty * P);
                    m_duty     = m_next;
                    m_count[g] = (m_count[g] + int'(prev_step)) % 512;
                    pc[g] = 0; hi = 0; dis = 0;
                end
                chk($sformatf("count%0d", g), int'(count[g]), m_count[g]);
                chk($sformatf("duty%0d", g), int'(duty[g]), m_duty);
                if (prev_ps) chk($sformatf("ps_width%0d", g), int'(period_start[g]), 0);
                if (!prev_en) chk($sformatf("pwm_dis%0d", g), int'(pwm_out[g]), 0);
                pc[g]++;
                if (pwm_out[g]) hi++;
                if (!en) dis++;
                // Sample for the current phase, used as next period's duty.
                if (pc[g] == 8) m_next = src(m_count[g]);
                prev_en   = en;
                prev_ps   = period_start[g];
                prev_step = step;
            end
        end
    end

    // Advance to posedge+1 of the cycle where instance 0 reports position n.
    task automatic wait_pc(input int n);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (pc[0] != n && k < 3000);
        if (pc[0] != n) chk("wait_timeout", pc[0], n);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_pwm%0d", tag, i), int'(pwm_out[i]), 0);
            chk($sformatf("%s_count%0d", tag, i), int'(count[i]), 0);
            chk($sformatf("%s_duty%0d", tag, i), int'(duty[i]), 0);
            chk($sformatf("%s_ps%0d", tag, i), int'(period_start[i]), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++)
            sine[i] = int'($floor(127.5 + 127.5 * $sin(6.283185307179586 * i / 512.0)));

        // Reset state, constant 64 stub, step 0.
        #1 rst_n = 1'b0;
        #11;
        chk_reset_state("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) wait_pc(128);
        chk("duty64", int'(duty[0]), 64);

        // Real table, random steps at random points in the period.
        mode_tab = 1'b1;
        step     = 9'd3;
        for (int p = 0; p < 10; p++) begin
            wait_pc($urandom_range(2, 255));
            step = 9'($urandom_range(0, 511));
        end
        // Step change on the period-end cycle itself.
        wait_pc(255);
        step = 9'($urandom_range(1, 511));
        wait_pc(128);

        // Drive the phase to 510, then step 3 wraps it to 1.
        step = 9'((510 - m_count[0] + 512) % 512);
        wait_pc(128);
        chk("prewrap", int'(count[0]), 510);
        step = 9'd3;
        wait_pc(128);
        chk("wrap", int'(count[0]), 1);
        step = 9'd0;
        repeat (2) wait_pc(128);
        chk("hold", int'(count[0]), 1);

        // Full-scale and zero duty.
        mode_tab = 1'b0;
        cval     = 255;
        repeat (2) wait_pc(128);
        chk("duty255", int'(duty[0]), 255);
        cval = 0;
        repeat (2) wait_pc(128);
        chk("duty0", int'(duty[0]), 0);

        // Enable gaps.
        mode_tab = 1'b1;
        step     = 9'd37;
        wait_pc(128);
        wait_pc(100);
        en = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wait_pc($urandom_range(20, 250));
            en = 1'b0;
            repeat ($urandom_range(1, 20)) begin @(posedge clk); #1; end
            en = 1'b1;
        end
        repeat (2) wait_pc(128);

        // Async reset while pwm_out is high.
        mode_tab = 1'b0;
        cval     = 200;
        repeat (2) wait_pc(128);
        wait_pc(50);
        chk("pre_rst_hi", int'(pwm_out[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_state("async");
        cval = 64;
        step = 9'd0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        wait_pc(128);
        chk("restart_p1", int'(duty[0]), 0);
        repeat (2) wait_pc(128);
        chk("restart_p3", int'(duty[0]), 64);
        repeat (4) wait_pc(128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sin_pwm_dac.md
Name: sin_pwm_dac

Overview:
Output stage of the sine generator. It owns the 9-bit phase address (count) that feeds the sine lookup block and captures the 8-bit sample (val) that block returns. Each captured sample becomes the duty cycle of one 256-tick PWM period on pwm_out, which drives the board's RC-filtered DAC pin. The phase advances by a programmable step once per PWM period, which sets the output tone frequency.

Parameters:
PRESCALE, 1, clk cycles per PWM tick (>=1)
ROM_LAT, 1, clk cycles from a count change to valid val at the sine block output (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; low freezes the phase and the PWM
step  input  9  phase increment applied at each period end
val  input  8  sample from the sine lookup block
count  output  9  phase address to the sine lookup block
pwm_out  output  1  PWM DAC output
period_start  output  1  one-cycle pulse on the first cycle of each PWM period
duty  output  8  duty value of the current period

Behaviour:
- Reset (async, rst_n=0) values:
  - count=0, duty=0, duty_next=0, pwm_cnt=0, presc=0, pwm_out=0, period_start=0.
  - Capture pipeline loaded with a single pending capture.
- Reset mid-operation forces all of the above immediately; pwm_out drops low without waiting for a clock edge.
- Tick generation:
  - tick = en && presc==PRESCALE-1.
  - On tick, presc<=0 and pwm_cnt<=pwm_cnt+1 (8-bit, wraps 255->0).
  - Otherwise, if en is high, presc increments.
  - With en low, presc and pwm_cnt hold.
- PWM output:
  - Registered every cycle: pwm_out <= en && (pwm_cnt < duty). This is one cycle behind pwm_cnt.
  - duty=0 gives pwm_out always low.
  - duty=255 gives pwm_out high for 255 of 256 ticks.
- Period end (tick while pwm_cnt==255):
  - pwm_cnt<=0.
  - duty<=duty_next.
  - count<=(count+step) mod 512. The step value sampled is the one present on that cycle.
  - period_start<=1 for exactly one cycle. It is 0 on all other cycles.
- Sample fetch:
  - Every count update injects a pulse into a (ROM_LAT+1)-deep capture shift register.
  - When the pulse exits, duty_next<=val. That is ROM_LAT+1 clk edges after the count-update edge.
  - The capture pipeline runs regardless of en, so an in-flight fetch always completes.
  - The fetch latency is always much shorter than a period (ROM_LAT+1 < 256*PRESCALE), so duty_next is valid before the next period end.
- First period after reset runs with duty=0 (pwm_out low). The sample for count=0 is captured ROM_LAT+1 cycles after reset release and is used in the second period.
- step=0 holds count, so every period repeats the same duty.
- Wrap-around: count=510 with step=3 gives count=1. There is no carry out.
- en low mid-period:
  - pwm_out=0 from the next edge.
  - Counters freeze and the period is stretched by the number of disabled cycles.
  - duty and count are unchanged.
  - When en returns, the period resumes from the held pwm_cnt.
- Simultaneous events: a period end and a capture on the same edge is impossible under the fetch-latency bound above. If a new step arrives on the period-end cycle, the new step is used.

Test Plan:
1. PRESCALE=1, ROM_LAT=1, sine block stubbed to val=64 constant, step=0, en=1 after reset -> first 256 cycles pwm_out=0; each following period pwm_out high 64 cycles then low 192; period_start pulses every 256 cycles; duty=64 from period 2.
2. Real sine block connected, step=3 -> count sequence 0,3,6,... changes once per 256 cycles; from count=510 the next value is 1; each period's duty equals the sine table entry for the previous count.
3. val stub 255 then 0 -> duty=255 period: pwm_out high 255 cycles and low 1; duty=0 period: pwm_out never high.
4. en deasserted for 10 cycles at pwm_cnt=100 -> pwm_out low during the gap; that period lasts 266 cycles; count and duty unchanged; pwm_out high count for the period equals duty.
5. PRESCALE=4 -> period=1024 cycles; pwm_out high 4*duty cycles; period_start is still a single-cycle pulse.
6. rst_n pulsed low mid-period with pwm_out high -> pwm_out goes 0 without a clock edge; count=0, duty=0; the sequence restarts exactly as in scenario 1.
